// File: rtl/imm_gen_stage_if.sv
// Handshake bundle between decode control and the immediate generator.
// master drives instructions and consumes immediates; slave is the stage.
interface imm_gen_stage_if #(
    parameter int XLEN = 32,
    parameter int ILEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [ILEN-1:0] inst;
    logic [2:0]      fmt;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] imm_out;
    logic            fmt_err;

    modport master (
        output in_valid, inst, fmt, out_ready,
        input  in_ready, out_valid, imm_out, fmt_err
    );

    modport slave (
        input  in_valid, inst, fmt, out_ready,
        output in_ready, out_valid, imm_out, fmt_err
    );
endinterface

// File: rtl/imm_gen_stage.sv
// Pipelined RV32I/RV64I immediate generator.
// Output register (main) plus one skid entry keeps full throughput under
// backpressure; in_ready is a flop equal to "skid entry free".
module imm_gen_stage #(
    parameter int XLEN = 32,
    parameter int ILEN = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    imm_gen_stage_if.slave bus
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_gen_stage: XLEN must be 32 or 64");
    end
    if (ILEN != 32) begin : g_bad_ilen
        $error("imm_gen_stage: ILEN must be 32");
    end

    localparam logic [2:0] FMT_NONE  = 3'd0;
    localparam logic [2:0] FMT_I     = 3'd1;
    localparam logic [2:0] FMT_S     = 3'd2;
    localparam logic [2:0] FMT_B     = 3'd3;
    localparam logic [2:0] FMT_U     = 3'd4;
    localparam logic [2:0] FMT_J     = 3'd5;
    localparam logic [2:0] FMT_SHAMT = 3'd6;

    logic            s;
    logic [31:0]     low;
    logic            sign_fill;
    logic [5:0]      shamt;
    logic [XLEN-1:0] imm_new;
    logic            err_new;

    logic            main_valid_q, main_valid_d;
    logic [XLEN-1:0] main_imm_q,   main_imm_d;
    logic            main_err_q,   main_err_d;
    logic            skid_valid_q, skid_valid_d;
    logic [XLEN-1:0] skid_imm_q,   skid_imm_d;
    logic            skid_err_q,   skid_err_d;
    logic            in_ready_q;

    logic            accept;
    logic            xfer;

    // Opcode bits never contribute to an immediate.
    logic            unused_opcode;
    assign unused_opcode = ^bus.inst[6:0];

    assign s     = bus.inst[31];
    assign shamt = (XLEN == 64) ? bus.inst[25:20] : {1'b0, bus.inst[24:20]};

    // Immediate construction: low 32 bits per format, upper bits are the sign
    // for every signed format and zero for shamt/none/reserved.
    always_comb begin
        low       = '0;
        sign_fill = 1'b0;
        err_new   = 1'b0;
        case (bus.fmt)
            FMT_NONE: low = '0;
            FMT_I: begin
                low       = {{20{s}}, bus.inst[31:20]};
                sign_fill = 1'b1;
            end
            FMT_S: begin
                low       = {{20{s}}, bus.inst[31:25], bus.inst[11:7]};
                sign_fill = 1'b1;
            end
            FMT_B: begin
                low       = {{19{s}}, s, bus.inst[7], bus.inst[30:25],
                             bus.inst[11:8], 1'b0};
                sign_fill = 1'b1;
            end
            FMT_U: begin
                low       = {bus.inst[31:12], 12'b0};
                sign_fill = 1'b1;
            end
            FMT_J: begin
                low       = {{11{s}}, s, bus.inst[19:12], bus.inst[20],
                             bus.inst[30:21], 1'b0};
                sign_fill = 1'b1;
            end
            FMT_SHAMT: low = {26'b0, shamt};
            default: begin
                low     = '0;
                err_new = 1'b1;
            end
        endcase
        imm_new       = {XLEN{sign_fill & s}};
        imm_new[31:0] = low;
    end

    assign accept = bus.in_valid && in_ready_q;
    assign xfer   = main_valid_q && bus.out_ready;

    // Next state of the two entries; flush drops both valids but keeps data.
    always_comb begin
        main_valid_d = main_valid_q;
        main_imm_d   = main_imm_q;
        main_err_d   = main_err_q;
        skid_valid_d = skid_valid_q;
        skid_imm_d   = skid_imm_q;
        skid_err_d   = skid_err_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
            // in_ready is low here, so no accept can coincide.
            if (xfer) begin
                main_valid_d = 1'b1;
                main_imm_d   = skid_imm_q;
                main_err_d   = skid_err_q;
                skid_valid_d = 1'b0;
            end
        end else if (!main_valid_q || xfer) begin
            if (accept) begin
                main_valid_d = 1'b1;
                main_imm_d   = imm_new;
                main_err_d   = err_new;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_imm_d   = imm_new;
            skid_err_d   = err_new;
        end
    end

    // Entry registers with asynchronous reset; in_ready tracks the free skid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            main_imm_q   <= '0;
            main_err_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_imm_q   <= '0;
            skid_err_q   <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            main_valid_q <= main_valid_d;
            main_imm_q   <= main_imm_d;
            main_err_q   <= main_err_d;
            skid_valid_q <= skid_valid_d;
            skid_imm_q   <= skid_imm_d;
            skid_err_q   <= skid_err_d;
            in_ready_q   <= !skid_valid_d;
        end
    end

    assign bus.out_valid = main_valid_q;
    assign bus.imm_out   = main_imm_q;
    assign bus.fmt_err   = main_err_q;
    assign bus.in_ready  = in_ready_q;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Self-checking bench for imm_gen_stage: directed steps on XLEN=32 and
// XLEN=64 instances, then randomized traffic against a queue-based model.
module tb_imm_gen_stage;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush32 = 1'b0;
    logic flush64 = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    imm_gen_stage_if #(.XLEN(32)) b32 ();
    imm_gen_stage_if #(.XLEN(64)) b64 ();

    imm_gen_stage #(.XLEN(32)) dut32 (.clk(clk), .rst(rst), .flush(flush32), .bus(b32));
    imm_gen_stage #(.XLEN(64)) dut64 (.clk(clk), .rst(rst), .flush(flush64), .bus(b64));

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] imm;
        logic        err;
    } exp_t;

    exp_t q32[$];
    exp_t q64[$];

    logic [31:0] f_inst [5] = '{32'hFFF00093, 32'hFE20AE23, 32'hFE000CE3, 32'h123450B7, 32'h0010006F};
    logic [2:0]  f_fmt  [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
    logic [31:0] f_exp  [5] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'h12345000, 32'h00000800};

    // Arithmetic reference: fields weighted by their bit position.
    function automatic logic [63:0] ref_imm(input int xlen, input logic [31:0] w, input logic [2:0] f);
        longint r;
        longint sw;
        longint neg;
        sw = longint'($signed(w));
        case (f)
            3'd1: r = sw >>> 20;
            3'd2: r = (sw >>> 25) * 32 + longint'(w[11:7]);
            3'd3: begin
                neg = w[31] ? -4096 : 0;
                r = neg + longint'(w[7]) * 2048 + longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2;
            end
            3'd4: r = longint'($signed(w & 32'hFFFFF000));
            3'd5: begin
                neg = w[31] ? -(1 << 20) : 0;
                r = neg + longint'(w[19:12]) * 4096 + longint'(w[20]) * 2048 + longint'(w[30:21]) * 2;
            end
            3'd6: r = (xlen == 64) ? longint'(w[25:20]) : longint'(w[24:20]);
            default: r = 0;
        endcase
        if (xlen == 32) r = r & 64'h0000_0000_FFFF_FFFF;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive32(input logic v, input logic [31:0] w, input logic [2:0] f);
        b32.in_valid = v;
        b32.inst     = w;
        b32.fmt      = f;
    endtask

    task automatic drive64(input logic v, input logic [31:0] w, input logic [2:0] f);
        b64.in_valid = v;
        b64.inst     = w;
        b64.fmt      = f;
    endtask

    task automatic pulse_reset;
        #2;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    initial begin
        logic        acc32, acc64, xfr32, xfr64;
        logic [31:0] w;
        drive32(1'b0, 32'h0, 3'd0);
        drive64(1'b0, 32'h0, 3'd0);
        b32.out_ready = 1'b1;
        b64.out_ready = 1'b1;

        // Reset state
        #1;
        chk("rst_out_valid", b32.out_valid, 1'b0);
        chk("rst_imm", b32.imm_out, 32'h0);
        chk("rst_fmt_err", b32.fmt_err, 1'b0);
        chk("rst64_out_valid", b64.out_valid, 1'b0);
        #21;
        rst = 1'b0;
        tick();
        chk("post_rst_in_ready", b32.in_ready, 1'b1);

        // One format per cycle, 1-cycle latency, no backpressure
        for (int i = 0; i < 5; i++) begin
            drive32(1'b1, f_inst[i], f_fmt[i]);
            tick();
            chk($sformatf("fmt%0d_valid", i), b32.out_valid, 1'b1);
            chk($sformatf("fmt%0d_imm", i), b32.imm_out, f_exp[i]);
            chk($sformatf("fmt%0d_err", i), b32.fmt_err, 1'b0);
            chk($sformatf("fmt%0d_in_ready", i), b32.in_ready, 1'b1);
        end
        drive32(1'b0, 32'h0, 3'd0);
        tick();
        chk("fmt_drain_valid", b32.out_valid, 1'b0);

        // XLEN=64 instance
        drive64(1'b1, 32'h800000B7, 3'd4);
        tick();
        chk("x64_u_imm", b64.imm_out, 64'hFFFFFFFF80000000);
        drive64(1'b1, 32'h03F09093, 3'd6);
        tick();
        chk("x64_shamt_imm", b64.imm_out, 64'h000000000000003F);
        chk("x64_shamt_valid", b64.out_valid, 1'b1);
        drive64(1'b0, 32'h0, 3'd0);
        tick();

        // Backpressure through the skid entry
        b32.out_ready = 1'b0;
        drive32(1'b1, 32'h00100093, 3'd1);
        tick();
        chk("bp_first_imm", b32.imm_out, 32'h1);
        chk("bp_first_in_ready", b32.in_ready, 1'b1);
        drive32(1'b1, 32'h00200093, 3'd1);
        tick();
        chk("bp_skid_in_ready", b32.in_ready, 1'b0);
        chk("bp_skid_hold_imm", b32.imm_out, 32'h1);
        drive32(1'b0, 32'h0, 3'd0);
        tick();
        chk("bp_hold_valid", b32.out_valid, 1'b1);
        chk("bp_hold_imm", b32.imm_out, 32'h1);
        b32.out_ready = 1'b1;
        tick();
        chk("bp_second_valid", b32.out_valid, 1'b1);
        chk("bp_second_imm", b32.imm_out, 32'h2);
        chk("bp_release_in_ready", b32.in_ready, 1'b1);
        tick();
        chk("bp_empty_valid", b32.out_valid, 1'b0);

        // Flush with both entries full and an input offered
        b32.out_ready = 1'b0;
        drive32(1'b1, 32'h00300093, 3'd1);
        tick();
        drive32(1'b1, 32'h00400093, 3'd1);
        tick();
        chk("fl_full_in_ready", b32.in_ready, 1'b0);
        flush32 = 1'b1;
        drive32(1'b1, 32'h00500093, 3'd1);
        tick();
        chk("fl_out_valid", b32.out_valid, 1'b0);
        chk("fl_in_ready", b32.in_ready, 1'b1);
        chk("fl_imm_held", b32.imm_out, 32'h3);
        flush32 = 1'b0;
        drive32(1'b0, 32'h0, 3'd0);
        b32.out_ready = 1'b1;
        tick();
        chk("fl_nothing_emerges", b32.out_valid, 1'b0);

        // Reserved format then a normal one
        w = $urandom;
        drive32(1'b1, w, 3'd7);
        tick();
        chk("rsv_valid", b32.out_valid, 1'b1);
        chk("rsv_imm", b32.imm_out, 32'h0);
        chk("rsv_err", b32.fmt_err, 1'b1);
        drive32(1'b1, 32'h00100093, 3'd1);
        tick();
        chk("rsv_clear_err", b32.fmt_err, 1'b0);
        chk("rsv_clear_imm", b32.imm_out, 32'h1);
        drive32(1'b0, 32'h0, 3'd0);
        tick();

        // Asynchronous reset with both entries full
        b32.out_ready = 1'b0;
        drive32(1'b1, 32'h00600093, 3'd1);
        tick();
        drive32(1'b1, 32'h00700093, 3'd7);
        tick();
        drive32(1'b0, 32'h0, 3'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", b32.out_valid, 1'b0);
        chk("arst_imm", b32.imm_out, 32'h0);
        chk("arst_err", b32.fmt_err, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("arst_in_ready", b32.in_ready, 1'b1);
        chk("arst_idle_valid", b32.out_valid, 1'b0);
        b32.out_ready = 1'b1;
        drive32(1'b1, 32'h00800093, 3'd1);
        tick();
        chk("arst_first_valid", b32.out_valid, 1'b1);
        chk("arst_first_imm", b32.imm_out, 32'h8);
        drive32(1'b0, 32'h0, 3'd0);
        tick();

        // Randomized traffic on both widths against the queue model
        pulse_reset();
        for (int c = 0; c < 600; c++) begin
            chk("rnd32_valid", b32.out_valid, q32.size() > 0);
            chk("rnd32_in_ready", b32.in_ready, q32.size() < 2);
            if (q32.size() > 0) begin
                chk("rnd32_imm", b32.imm_out, q32[0].imm);
                chk("rnd32_err", b32.fmt_err, q32[0].err);
            end
            chk("rnd64_valid", b64.out_valid, q64.size() > 0);
            chk("rnd64_in_ready", b64.in_ready, q64.size() < 2);
            if (q64.size() > 0) begin
                chk("rnd64_imm", b64.imm_out, q64[0].imm);
                chk("rnd64_err", b64.fmt_err, q64[0].err);
            end

            drive32($urandom_range(0, 3) != 0, $urandom, 3'($urandom_range(0, 7)));
            drive64($urandom_range(0, 3) != 0, $urandom, 3'($urandom_range(0, 7)));
            b32.out_ready = $urandom_range(0, 2) != 0;
            b64.out_ready = $urandom_range(0, 2) != 0;
            flush32 = $urandom_range(0, 31) == 0;
            flush64 = $urandom_range(0, 31) == 0;
            acc32 = b32.in_valid && (q32.size() < 2);
            acc64 = b64.in_valid && (q64.size() < 2);
            xfr32 = (q32.size() > 0) && b32.out_ready;
            xfr64 = (q64.size() > 0) && b64.out_ready;

            @(posedge clk);
            if (flush32) q32.delete();
            else begin
                if (xfr32) void'(q32.pop_front());
                if (acc32) q32.push_back('{ref_imm(32, b32.inst, b32.fmt), b32.fmt == 3'd7});
            end
            if (flush64) q64.delete();
            else begin
                if (xfr64) void'(q64.pop_front());
                if (acc64) q64.push_back('{ref_imm(64, b64.inst, b64.fmt), b64.fmt == 3'd7});
            end
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
